score_arbiter: RTL and testbench
================================

// Module: score_arbiter
// PURPOSE
// - Sole writer of the score register. Arbitrates point-award requests from
//   NREQ sources (pellet eater, fruit handler, ghost-eaten logic) and does
//   one serialized read-modify-write per grant.
// - Drives the register's Load_S/score_to_reg. Flags the win threshold
//   for the game FSM.
// PARAMETERS
// - NREQ       3     number of requesters (>=2)
// - SCORE_W    10    score register width
// - PTS_W      8     per-request point value width
// - WIN_SCORE  520   threshold that sets win_reached
// - MAX_SCORE  1023  saturation ceiling (<= 2**SCORE_W-1)
// PORTS
// - Clk             in   1              system clock, rising edge
// - Reset_n         in   1              async active-low reset
// - clear           in   1              sync restart: zero score, flush requests
// - req             in   NREQ           request per source, held until ack
// - pts             in   NREQ*PTS_W     points; source i at [i*PTS_W +: PTS_W]
// - ack             out  NREQ           one-cycle grant-complete pulse per source
// - score_from_reg  in   SCORE_W        current score register value
// - score_to_reg    out  SCORE_W        value to load
// - Load_S          out  1              score register load enable
// - busy            out  1              high whenever state != IDLE
// - win_reached     out  1              sticky: score >= WIN_SCORE
// - hiscore         out  SCORE_W        best score (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, Reset_n=0): state=IDLE, ack=0, Load_S=0, score_to_reg=0,
//   busy=0, win_reached=0, hiscore=0, rr_ptr=NREQ-1 (so source 0 wins first).
// - FSM states:
//   - IDLE: if any req, pick winner round-robin starting at rr_ptr+1 mod NREQ.
//     Latch id and pts[id], set rr_ptr=id, go to ADD.
//   - ADD: Load_S=1, score_to_reg=sat(score_from_reg+pts_lat),
//     ack[id]=1. Go to SETTLE.
//   - SETTLE: one dead cycle so the register update is visible, and so the
//     requester can drop req. Go to IDLE.
// - Latency: req seen high in IDLE cycle n -> ack and Load_S in cycle n+1.
//   Max throughput is one award per 3 cycles.
// - Handshake:
//   - Requester keeps req and pts stable until it sees ack.
//   - Requester drops req on the edge after ack.
//   - A req still high in the IDLE that follows is a new request.
// - Arithmetic: sum is formed in SCORE_W+1 bits. If sum > MAX_SCORE,
//   score_to_reg=MAX_SCORE. A pts=0 request is still granted; it loads an
//   unchanged value and acks.
// - win_reached: set in ADD when score_to_reg >= WIN_SCORE. Cleared only by
//   reset or clear.
// - clear (highest priority, any state):
//   - That cycle: Load_S=1, score_to_reg=0, ack=req (flush all asserted
//     requests, no points added). In-flight ADD is cancelled.
//   - win_reached<=0, next state IDLE. rr_ptr is unchanged.
// - Simultaneous requests: exactly one grant per ADD. No source waits more
//   than NREQ grants. A new req arriving during ADD/SETTLE waits for IDLE.
// - ack and Load_S are never high outside ADD or a clear cycle.
// - Reset mid-operation: immediate return to reset values; no ack is issued.
// CONFIGURATION
// - SCORE_HISCORE_EN defined:
//   - In SETTLE, if score_from_reg > hiscore, then hiscore<=score_from_reg.
//   - hiscore survives clear; only Reset_n zeroes it.
// - SCORE_HISCORE_EN undefined: hiscore is tied to 0 and no register is
//   inferred.
// TESTING
// - Reset: Reset_n=0 mid-ADD -> ack=0, Load_S=0, busy=0, win_reached=0
//   immediately.
// - Single award: score=0, req=3'b001, pts0=10 -> cycle+1 has ack=3'b001,
//   Load_S=1, score_to_reg=10. busy high for 2 cycles.
// - Contention: req=3'b111, pts={200,50,10}, score=0 -> acks arrive in
//   order 0,1,2, 3 cycles apart. Loads are 10, 60, 260.
// - Saturation/win: score=470 +50 -> 520, win_reached=1. score=1000 +50
//   -> 1023.
// - Clear: clear=1 during ADD with req=3'b110 -> Load_S=1, score_to_reg=0,
//   ack=3'b110. No points added, win_reached=0.
// - Hiscore (SCORE_HISCORE_EN): reach 300, then clear, then reach 120 ->
//   hiscore=300. Without the macro, hiscore=0 throughout.

Source files
------------

// File: rtl/score_arbiter.sv
// Round-robin arbiter and sole read-modify-write writer of the score register.
// Optional SCORE_HISCORE_EN macro adds a best-score register on hiscore.
module score_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned SCORE_W   = 10,
    parameter int unsigned PTS_W     = 8,
    parameter int unsigned WIN_SCORE = 520,
    parameter int unsigned MAX_SCORE = 1023
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*PTS_W-1:0] pts,
    output logic [NREQ-1:0]       ack,
    input  logic [SCORE_W-1:0]    score_from_reg,
    output logic [SCORE_W-1:0]    score_to_reg,
    output logic                  Load_S,
    output logic                  busy,
    output logic                  win_reached,
    output logic [SCORE_W-1:0]    hiscore
);

    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SUM_W = SCORE_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [NREQ-1:0]     ack_q;
    logic                load_q;
    logic [SCORE_W-1:0]  score_q;
    logic                win_q;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand;
    logic [PTS_W-1:0]    win_pts;
    logic [SUM_W-1:0]    sum;
    logic [SCORE_W-1:0]  sat_sum;

    // Round-robin search starting one past the last winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Saturating add in SCORE_W+1 bits; score_from_reg is stable in IDLE.
    always_comb begin
        win_pts = pts[32'(win_id) * PTS_W +: PTS_W];
        sum     = SUM_W'(score_from_reg) + SUM_W'(win_pts);
        sat_sum = (sum > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            rr_ptr  <= ID_W'(NREQ - 1);
            ack_q   <= '0;
            load_q  <= 1'b0;
            score_q <= '0;
            win_q   <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            ack_q   <= '0;
            load_q  <= 1'b0;
            score_q <= '0;
            win_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q  <= '0;
                    load_q <= 1'b0;
                    if (win_found) begin
                        state   <= ADD;
                        rr_ptr  <= win_id;
                        ack_q   <= NREQ'(1) << win_id;
                        load_q  <= 1'b1;
                        score_q <= sat_sum;
                    end
                end
                ADD: begin
                    state  <= SETTLE;
                    ack_q  <= '0;
                    load_q <= 1'b0;
                    if (score_q >= SCORE_W'(WIN_SCORE)) begin
                        win_q <= 1'b1;
                    end
                end
                SETTLE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    ack_q  <= '0;
                    load_q <= 1'b0;
                end
            endcase
        end
    end

    // clear acts in its own cycle: zero load and flush of every asserted request.
    assign ack          = (clear && Reset_n) ? req : ack_q;
    assign Load_S       = (clear && Reset_n) | load_q;
    assign score_to_reg = clear ? '0 : score_q;
    assign busy         = (state != IDLE);
    assign win_reached  = win_q;

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;

    // Best score survives clear; the register value is fresh in SETTLE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hiscore_q <= '0;
        end else if (state == SETTLE && score_from_reg > hiscore_q) begin
            hiscore_q <= score_from_reg;
        end
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = '0;
`endif

endmodule

// File: tb/tb_score_arbiter.sv
// Scoreboard bench for score_arbiter with a behavioural score register.
module tb_score_arbiter;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned SCORE_W = 10;
    localparam int unsigned PTS_W   = 8;
`ifdef SCORE_HISCORE_EN
    localparam int unsigned EXP_HI = 300;
`else
    localparam int unsigned EXP_HI = 0;
`endif

    typedef struct {
        logic [NREQ-1:0]    ack;
        logic [SCORE_W-1:0] score;
        int                 cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clear;
    logic [NREQ-1:0]       req;
    logic [NREQ*PTS_W-1:0] pts;
    logic [NREQ-1:0]       ack;
    logic [SCORE_W-1:0]    score_reg = '0;
    logic [SCORE_W-1:0]    score_to_reg;
    logic                  load_s;
    logic                  busy;
    logic                  win_reached;
    logic [SCORE_W-1:0]    hiscore;
    logic                  preset_en = 1'b0;
    logic [SCORE_W-1:0]    preset_val = '0;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    score_arbiter dut (
        .Clk           (clk),
        .Reset_n       (rst_n),
        .clear         (clear),
        .req           (req),
        .pts           (pts),
        .ack           (ack),
        .score_from_reg(score_reg),
        .score_to_reg  (score_to_reg),
        .Load_S        (load_s),
        .busy          (busy),
        .win_reached   (win_reached),
        .hiscore       (hiscore)
    );

    always #5 clk = ~clk;

    // Score register model, with a back door to preset test scores.
    always @(posedge clk) begin
        if (load_s)         score_reg <= score_to_reg;
        else if (preset_en) score_reg <= preset_val;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, score any load, requesters drop on ack.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (load_s) begin
                if (q.size() == 0) begin
                    chk_eq("load_without_expect", 32'(load_s), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk_eq("ack", 32'(ack), 32'(e.ack));
                    chk_eq("score_to_reg", 32'(score_to_reg), 32'(e.score));
                    if (e.cyc >= 0) chk_eq("latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (ack != '0) begin
                chk_eq("ack_without_load", 32'(ack), 32'd0);
            end
        end
        req = req & ~ack;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        logic done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            cycle();
            if (q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk_eq({"drain_", tag}, 32'(done), 32'd1);
    endtask

    task automatic preset(input int unsigned v);
        preset_val = SCORE_W'(v);
        preset_en  = 1'b1;
        cycle();
        preset_en  = 1'b0;
    endtask

    task automatic award(input int unsigned src, input int unsigned p, input int unsigned exp_score);
        exp_t e;
        pts[src*PTS_W +: PTS_W] = PTS_W'(p);
        req[src] = 1'b1;
        e.ack   = NREQ'(1) << src;
        e.score = SCORE_W'(exp_score);
        e.cyc   = cyc + 1;
        q.push_back(e);
        wait_done("award", 20);
    endtask

    // Assert clear for exactly one clock cycle, aligned to a rising edge.
    task automatic do_clear(input logic [NREQ-1:0] exp_ack, input logic exp_busy);
        exp_t e;
        @(posedge clk);
        #1;
        clear = 1'b1;
        chk_eq("busy_at_clear", 32'(busy), 32'(exp_busy));
        e.ack   = exp_ack;
        e.score = '0;
        e.cyc   = cyc + 1;
        q.push_back(e);
        cycle();
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c;
        rst_n = 1'b0;
        clear = 1'b0;
        req   = '0;
        pts   = '0;
        repeat (2) @(negedge clk);
        chk_eq("rst_ack", 32'(ack), 32'd0);
        chk_eq("rst_load", 32'(load_s), 32'd0);
        chk_eq("rst_score", 32'(score_to_reg), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_win", 32'(win_reached), 32'd0);
        chk_eq("rst_hiscore", 32'(hiscore), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Contention: grants in order 0,1,2, three cycles apart.
        pts = {8'd200, 8'd50, 8'd10};
        req = 3'b111;
        c   = cyc;
        e.ack = 3'b001; e.score = 10'd10;  e.cyc = c + 1; q.push_back(e);
        e.ack = 3'b010; e.score = 10'd60;  e.cyc = c + 4; q.push_back(e);
        e.ack = 3'b100; e.score = 10'd260; e.cyc = c + 7; q.push_back(e);
        wait_done("contention", 30);
        chk_eq("win_below", 32'(win_reached), 32'd0);

        // Single award with busy profile.
        preset(0);
        pts[0 +: PTS_W] = 8'd10;
        req[0] = 1'b1;
        e.ack = 3'b001; e.score = 10'd10; e.cyc = cyc + 1; q.push_back(e);
        cycle();
        chk_eq("busy_add", 32'(busy), 32'd1);
        cycle();
        chk_eq("busy_settle", 32'(busy), 32'd1);
        cycle();
        chk_eq("busy_idle", 32'(busy), 32'd0);
        wait_done("single", 10);

        // Win threshold, saturation, zero-point grant.
        preset(470);
        award(1, 50, 520);
        chk_eq("win_set", 32'(win_reached), 32'd1);
        preset(1000);
        award(0, 50, 1023);
        chk_eq("win_sticky", 32'(win_reached), 32'd1);
        award(2, 0, 1023);

        // Clear landing on an ADD flushes both requesters.
        preset(100);
        pts[1*PTS_W +: PTS_W] = 8'd5;
        pts[2*PTS_W +: PTS_W] = 8'd7;
        req = 3'b110;
        do_clear(3'b110, 1'b1);
        wait_done("clear", 10);
        repeat (3) cycle();
        chk_eq("win_cleared", 32'(win_reached), 32'd0);
        chk_eq("busy_after_clear", 32'(busy), 32'd0);
        chk_eq("req_flushed", 32'(req), 32'd0);

        // Reset in the middle of an ADD.
        preset(515);
        award(0, 10, 525);
        chk_eq("win_again", 32'(win_reached), 32'd1);
        preset(0);
        pts[0 +: PTS_W] = 8'd10;
        req[0] = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("mid_add_load", 32'(load_s), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_ack", 32'(ack), 32'd0);
        chk_eq("mid_rst_load", 32'(load_s), 32'd0);
        chk_eq("mid_rst_busy", 32'(busy), 32'd0);
        chk_eq("mid_rst_win", 32'(win_reached), 32'd0);
        req = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk_eq("rst_hiscore2", 32'(hiscore), 32'd0);

        // Best score survives clear.
        award(0, 200, 200);
        award(0, 100, 300);
        do_clear(3'b000, 1'b0);
        wait_done("clear_idle", 10);
        chk_eq("hiscore_after_clear", 32'(hiscore), 32'(EXP_HI));
        award(0, 120, 120);
        chk_eq("hiscore_kept", 32'(hiscore), 32'(EXP_HI));
        chk_eq("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
